// File: rtl/sub_64_bk_ks_pipe_if.sv
// Operand/result handshake bundle for the pipelined 64-bit prefix subtractor.
// The master side drives operands and out_ready; the slave side is the subtractor.
interface sub_64_bk_ks_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;
  logic        lt_s;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf, lt_s
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf, lt_s
  );
endinterface

// File: rtl/sub_64_bk_ks_pipe.sv
// 3-stage 64-bit subtractor diff = a + ~b + ~bin, built on a Brent-Kung (within
// 8-bit groups) plus Kogge-Stone (across groups) prefix network, with borrow/flag outputs.
module sub_64_bk_ks_pipe #(
  parameter int WIDTH = 64,
  parameter int GROUP = 8
) (
  input logic clk,
  input logic rst_n,
  sub_64_bk_ks_pipe_if.slave bus
);

  if (WIDTH != 64 || GROUP != 8) begin : g_bad_param
    $error("sub_64_bk_ks_pipe: only WIDTH=64 and GROUP=8 are supported");
  end

  logic advance;

  // Stage 1: per-position generate/propagate; position 0 carries the inverted borrow-in.
  logic        v1;
  logic [64:0] s1_g;
  logic [64:0] s1_p;
  logic        s1_a63;
  logic        s1_b63;

  // Stage 2: in-group prefixes plus the raw propagates needed for the final sum.
  logic        v2;
  logic [63:0] s2_g;
  logic [63:0] s2_p;
  logic [63:0] s2_pr;
  logic        s2_g64;
  logic        s2_a63;
  logic        s2_b63;

  // Stage 3: registered result and flags.
  logic        v3;
  logic [63:0] r_diff;
  logic        r_bout;
  logic        r_zero;
  logic        r_ovf;
  logic        r_lt_s;

  assign advance       = ~v3 | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v3;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign bus.lt_s      = r_lt_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_g   <= '0;
      s1_p   <= '0;
      s1_a63 <= 1'b0;
      s1_b63 <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_g   <= {bus.a & ~bus.b, ~bus.bin};
        s1_p   <= {bus.a ^ ~bus.b, 1'b0};
        s1_a63 <= bus.a[63];
        s1_b63 <= bus.b[63];
      end
    end
  end

  logic [63:0] bk_g;
  logic [63:0] bk_p;

  // Up-sweep spans 2/4/8, then down-sweep fills the remaining in-group positions.
  always_comb begin
    bk_g = s1_g[63:0];
    bk_p = s1_p[63:0];
    for (int s = 1; s <= 4; s = s * 2) begin
      for (int i = 2 * s - 1; i < 64; i = i + 2 * s) begin
        bk_g[i] = bk_g[i] | (bk_p[i] & bk_g[i - s]);
        bk_p[i] = bk_p[i] & bk_p[i - s];
      end
    end
    for (int i = 5; i < 64; i = i + 8) begin
      bk_g[i] = bk_g[i] | (bk_p[i] & bk_g[i - 2]);
      bk_p[i] = bk_p[i] & bk_p[i - 2];
    end
    for (int i = 2; i < 64; i = i + 2) begin
      if ((i % 8) != 0) begin
        bk_g[i] = bk_g[i] | (bk_p[i] & bk_g[i - 1]);
        bk_p[i] = bk_p[i] & bk_p[i - 1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_g   <= '0;
      s2_p   <= '0;
      s2_pr  <= '0;
      s2_g64 <= 1'b0;
      s2_a63 <= 1'b0;
      s2_b63 <= 1'b0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        s2_g   <= bk_g;
        s2_p   <= bk_p;
        s2_pr  <= s1_p[64:1];
        s2_g64 <= s1_g[64];
        s2_a63 <= s1_a63;
        s2_b63 <= s1_b63;
      end
    end
  end

  logic [7:0]  ks_g;
  logic [7:0]  ks_p;
  logic [7:0]  nx_g;
  logic [7:0]  nx_p;
  logic [63:0] carry;
  logic [63:0] d_nxt;
  logic        c64;
  logic        ovf_nxt;

  // Kogge-Stone across the eight group terms (bit spans 8, 16, 32).
  always_comb begin
    nx_g = '0;
    nx_p = '0;
    for (int j = 0; j < 8; j++) begin
      ks_g[j] = s2_g[8 * j + 7];
      ks_p[j] = s2_p[8 * j + 7];
    end
    for (int d = 1; d < 8; d = d * 2) begin
      nx_g = ks_g;
      nx_p = ks_p;
      for (int j = d; j < 8; j++) begin
        nx_g[j] = ks_g[j] | (ks_p[j] & ks_g[j - d]);
        nx_p[j] = ks_p[j] & ks_p[j - d];
      end
      ks_g = nx_g;
      ks_p = nx_p;
    end
    carry[7:0] = s2_g[7:0];
    for (int j = 1; j < 8; j++) begin
      carry[8 * j +: 8] = s2_g[8 * j +: 8] | (s2_p[8 * j +: 8] & {8{ks_g[j - 1]}});
    end
    d_nxt   = s2_pr ^ carry;
    c64     = s2_g64 | (s2_pr[63] & carry[63]);
    ovf_nxt = (s2_a63 ^ s2_b63) & (d_nxt[63] ^ s2_a63);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_lt_s <= 1'b0;
    end else if (advance) begin
      v3 <= v2;
      if (v2) begin
        r_diff <= d_nxt;
        r_bout <= ~c64;
        r_zero <= ~|d_nxt;
        r_ovf  <= ovf_nxt;
        r_lt_s <= d_nxt[63] ^ ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sub_64_bk_ks_pipe.sv
// Bench for the pipelined 64-bit subtractor: scoreboard of expected results fed at
// acceptance and drained at retirement, plus per-scenario checks of fixed values.
module tb_sub_64_bk_ks_pipe;

  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    logic        lt_s;
  } res_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   n_out;
  logic hold_pend;
  res_t snap;
  res_t exp_q[$];
  res_t got_q[$];

  sub_64_bk_ks_pipe_if bus ();

  sub_64_bk_ks_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic bi);
    res_t r;
    logic [64:0] w;
    logic signed [65:0] s;
    w = {1'b0, x} - {1'b0, y} - {64'd0, bi};
    s = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, bi});
    r.diff = w[63:0];
    r.bout = w[64];
    r.zero = (w[63:0] == 64'd0);
    r.lt_s = (s < 0);
    r.ovf  = (s != $signed({{2{w[63]}}, w[63:0]}));
    return r;
  endfunction

  // Scoreboard and output-stability monitor, sampled on the falling edge.
  initial begin : monitor
    res_t cur;
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cur = {bus.diff, bus.bout, bus.zero, bus.ovf, bus.lt_s};
        if (hold_pend) begin
          vectors++;
          if (bus.out_valid !== 1'b1 || cur !== snap) begin
            miscompares++;
            $display("FAIL hold: valid=%0b result=%h, held result must be %h", bus.out_valid, cur, snap);
          end
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        snap = cur;
        if (bus.out_valid && bus.out_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: result=%h with no op outstanding", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              miscompares++;
              $display("FAIL scoreboard: got %h expected %h", cur, e);
            end
          end
          got_q.push_back(cur);
          n_out++;
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.bin));
      end
    end
  end

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic bi);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.bin = bi;
    for (int k = 0; k < 30 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_out(input int target);
    for (int k = 0; k < 40 && n_out < target; k++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (n_out < target) begin
      miscompares++;
      $display("FAIL wait_timeout: outputs=%0d, required %0d", n_out, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold_pend = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.out_valid, bus.diff, bus.bout, bus.zero, bus.ovf, bus.lt_s} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b diff=%h flags=%b, required all 0", bus.out_valid,
               bus.diff, {bus.bout, bus.zero, bus.ovf, bus.lt_s});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: in_ready=%0b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    int base;
    base = n_out;
    bus.out_ready = 1'b1;
    send(64'h10, 64'h3, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: out_valid=%0b two cycles after accept, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: out_valid=%0b three cycles after accept, required 1", bus.out_valid);
    end
    wait_out(base + 1);
    vectors++;
    if (n_out > base && got_q[base] !== {64'hD, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_op: got %h, required diff=d flags=0000", got_q[base]);
    end
  endtask

  task automatic test_wrap();
    int base;
    base = n_out;
    send(64'h0, 64'h1, 1'b0);
    send(64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1);
    wait_out(base + 2);
    vectors++;
    if (n_out > base + 1 && got_q[base] !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_0_minus_1: got %h, required diff=all ones bout=1 ovf=0 lt_s=1", got_q[base]);
    end
    vectors++;
    if (n_out > base + 1 && (got_q[base + 1].diff !== 64'hFFFF_FFFF_FFFF_FFFF || got_q[base + 1].bout !== 1'b1)) begin
      miscompares++;
      $display("FAIL wrap_equal_bin: got %h, required diff=all ones bout=1", got_q[base + 1]);
    end
  endtask

  task automatic test_overflow_zero();
    int base;
    base = n_out;
    send(64'h8000_0000_0000_0000, 64'h1, 1'b0);
    send(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0);
    wait_out(base + 2);
    vectors++;
    if (n_out > base + 1 && got_q[base] !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL signed_ovf: got %h, required diff=7fff_ffff_ffff_ffff bout=0 ovf=1 lt_s=1", got_q[base]);
    end
    vectors++;
    if (n_out > base + 1 && (got_q[base + 1].zero !== 1'b1 || got_q[base + 1].diff !== 64'd0)) begin
      miscompares++;
      $display("FAIL zero_flag: got %h, required diff=0 zero=1", got_q[base + 1]);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int k;
    logic [63:0] oa [8];
    logic [63:0] ob [8];
    logic        obi[8];
    base = n_out;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      oa[i]  = {$urandom, $urandom};
      ob[i]  = {$urandom, $urandom};
      obi[i] = 1'($urandom_range(1));
    end
    for (int c = 0; c < 24; c++) begin
      bus.out_ready = !(c >= 4 && c <= 9);
      if (k < 8) begin
        bus.in_valid = 1'b1;
        bus.a = oa[k];
        bus.b = ob[k];
        bus.bin = obi[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 4 && c <= 10) begin
        vectors++;
        if (bus.in_ready !== (c == 10)) begin
          miscompares++;
          $display("FAIL stall_in_ready: cycle %0d in_ready=%0b, required %0b", c, bus.in_ready, (c == 10));
        end
      end
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_out(base + 8);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (k != 8 || n_out != base + 8 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count: accepted=%0d retired=%0d pending=%0d, required 8/8/0", k, n_out - base, exp_q.size());
    end
  endtask

  task automatic test_chain();
    int base;
    logic [63:0] diff_lo;
    logic        bout_lo;
    base = n_out;
    diff_lo = '0;
    bout_lo = 1'b0;
    send(64'h0, 64'h1, 1'b0);
    wait_out(base + 1);
    if (n_out > base) begin
      diff_lo = got_q[base].diff;
      bout_lo = got_q[base].bout;
    end
    send(64'h2, 64'h0, bout_lo);
    wait_out(base + 2);
    vectors++;
    if (diff_lo !== 64'hFFFF_FFFF_FFFF_FFFF || bout_lo !== 1'b1) begin
      miscompares++;
      $display("FAIL chain_lo: diff=%h bout=%0b, required all ones and 1", diff_lo, bout_lo);
    end
    vectors++;
    if (n_out > base + 1 && (got_q[base + 1].diff !== 64'h1 || got_q[base + 1].bout !== 1'b0)) begin
      miscompares++;
      $display("FAIL chain_hi: got %h, required diff=1 bout=0", got_q[base + 1]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bus.out_ready = 1'b0;
    send(64'h1111, 64'h1, 1'b0);
    send(64'h2222, 64'h2, 1'b0);
    send(64'h3333, 64'h3, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fill: out_valid=%0b with 3 items in flight, required 1", bus.out_valid);
    end
    base = n_out;
    rst_n = 1'b0;
    exp_q.delete();
    hold_pend = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.diff !== 64'd0) begin
      miscompares++;
      $display("FAIL async_reset: out_valid=%0b diff=%h, required 0 and 0", bus.out_valid, bus.diff);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_output: out_valid=%0b %0d cycles after reset, required 0", bus.out_valid, c + 1);
      end
    end
    send(64'd100, 64'd58, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_early: out_valid=%0b, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 64'd42) begin
      miscompares++;
      $display("FAIL post_reset_op: valid=%0b diff=%h, required 1 and 2a", bus.out_valid, bus.diff);
    end
    wait_out(base + 1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n_out = 0;
    hold_pend = 1'b0;
    snap = '0;
    test_reset();
    test_single();
    test_wrap();
    test_overflow_zero();
    test_backpressure();
    test_chain();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
